// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK bus
// levels and the byte width.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw scl/sda onto clk and derives bus events.
// Ports:
//   clk, rst          system clock, async active-high reset
//   scl_in, sda_in    raw bus pins
//   scl_s, sda_s      synchronized levels
//   scl_rise/scl_fall single-cycle edge strobes on scl_s
//   start/stop        single-cycle START / STOP condition strobes
// SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_d;
    logic                   sda_d;

    // Preset to 1 so a released (idle) bus produces no events out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
            scl_d  <= scl_sr[SYNC_STAGES-1];
            sda_d  <= sda_sr[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sr[SYNC_STAGES-1];
    assign sda_s    = sda_sr[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & sda_d & ~sda_s;
    assign stop     = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target with a one-entry receive holding register and a user-supplied
// transmit byte.
// Ports:
//   clk, rst        system clock (>= 8x scl), async active-high reset
//   scl_in, sda_in  raw bus pins
//   sda_oe          1 = pull sda low
//   rx_data/rx_valid/rx_ready  received-byte handshake
//   tx_data/tx_req  tx_data is sampled in the cycle tx_req is high
//   busy            between START and STOP
//   overrun         sticky: a write byte was NACKed because rx_valid was set
module i2c_slave_target #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       overrun
);

    import i2c_pkg::*;

    logic scl_s, sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t            state, state_n;
    logic [BYTE_W-1:0] shift, shift_n;
    logic [2:0]        cnt, cnt_n;
    logic              done, done_n;      // 8th scl_rise of the byte seen
    logic              rw, rw_n;
    logic              mack, mack_n;      // master's ACK bit after a read byte
    logic              sda_oe_n;
    logic [7:0]        rx_data_n;
    logic              rx_valid_n;
    logic              overrun_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            rw       <= 1'b0;
            mack     <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            cnt      <= cnt_n;
            done     <= done_n;
            rw       <= rw_n;
            mack     <= mack_n;
            sda_oe   <= sda_oe_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            overrun  <= overrun_n;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        cnt_n      = cnt;
        done_n     = done;
        rw_n       = rw;
        mack_n     = mack;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = rx_valid & ~rx_ready;
        overrun_n  = overrun;
        tx_req     = 1'b0;

        if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else if (start) begin
            state_n  = ADDR;
            cnt_n    = '0;
            done_n   = 1'b0;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[BYTE_W-2:0], sda_s};
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            // shift[6:0] already holds the 7 address bits;
                            // the bit arriving now is R/W.
                            rw_n = sda_s;
                            if (shift[BYTE_W-2:0] == SLAVE_ADDR)
                                done_n = 1'b1;
                            else
                                state_n = WAIT_STOP;
                        end
                    end else if (scl_fall && done) begin
                        done_n   = 1'b0;
                        sda_oe_n = 1'b1;
                        state_n  = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n = '0;
                        if (rw) begin
                            tx_req   = 1'b1;
                            shift_n  = tx_data;
                            sda_oe_n = ~tx_data[BYTE_W-1];
                            state_n  = TX_BYTE;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_n = {shift[BYTE_W-2:0], sda_s};
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7)
                            done_n = 1'b1;
                    end else if (scl_fall && done) begin
                        done_n  = 1'b0;
                        state_n = RX_ACK;
                        if (!rx_valid || rx_ready) begin
                            rx_data_n  = shift;
                            rx_valid_n = 1'b1;
                            sda_oe_n   = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            overrun_n = 1'b1;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = '0;
                        state_n  = RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7)
                            done_n = 1'b1;
                    end else if (scl_fall) begin
                        if (done) begin
                            done_n   = 1'b0;
                            sda_oe_n = 1'b0;
                            state_n  = TX_ACK;
                        end else begin
                            shift_n  = {shift[BYTE_W-2:0], 1'b0};
                            sda_oe_n = ~shift[BYTE_W-2];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        mack_n = sda_s;
                    end else if (scl_fall) begin
                        if (mack == I2C_ACK) begin
                            tx_req   = 1'b1;
                            shift_n  = tx_data;
                            sda_oe_n = ~tx_data[BYTE_W-1];
                            cnt_n    = '0;
                            state_n  = TX_BYTE;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = WAIT_STOP;
                        end
                    end
                end
                IDLE, WAIT_STOP: ;
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: a bus-master model drives scl/sda,
// received bytes are checked against a scoreboard queue.
module tb_i2c_slave_target;

    import i2c_pkg::*;

    localparam int Q = 5;   // clk cycles per quarter scl period

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       scl_in, sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_tab[0:1];
    int         tx_idx = 0;
    int         txreq_cycles = 0;
    bit         oe_seen = 1'b0;
    bit         rxv_seen = 1'b0;
    int         rxv_run = 0;
    int         rxv_max = 0;

    always #5 clk = ~clk;

    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    i2c_slave_target #(.SLAVE_ADDR(7'h20), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .overrun  (overrun)
    );

    always_comb tx_data = (tx_idx < 2) ? tx_tab[tx_idx] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk)
        if (tx_req) tx_idx <= tx_idx + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (sda_oe) oe_seen = 1'b1;
            if (rx_valid) rxv_seen = 1'b1;
            if (rx_valid) rxv_run++; else rxv_run = 0;
            if (rxv_run > rxv_max) rxv_max = rxv_run;
            if (tx_req) txreq_cycles++;
            if (rx_valid && rx_ready) begin
                check("rx_expected", 32'(rx_exp_q.size() != 0), 32'd1);
                if (rx_exp_q.size() != 0)
                    check("rx_data_sb", 32'(rx_data), 32'(rx_exp_q.pop_front()));
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start;
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic bus_stop;
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        m_sda = 1'b1; wclk(Q);
    endtask

    task automatic send_bit(input logic v);
        m_sda = v;    wclk(Q);
        m_scl = 1'b1; wclk(2*Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic recv_bit(output logic v, output logic oe);
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        v  = sda_in;
        oe = sda_oe;
        wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack, output logic oe);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack, oe);
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic v, oe;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(v, oe);
            b = {b[6:0], v};
        end
    endtask

    initial begin
        logic       ack, oe;
        logic [7:0] rb;
        logic [7:0] pat;

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rx_ready = 1'b1;
        tx_tab[0] = 8'h3C; tx_tab[1] = 8'hC3;
        wclk(3);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_tx_req",   32'(tx_req),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        rst = 1'b0;
        wclk(3);

        // Write 0x20 / 0xA5 with consumer ready
        rxv_max = 0;
        rx_exp_q.push_back(8'hA5);
        bus_start;
        check("t1_busy_start", 32'(busy), 32'd1);
        write_byte(8'h40, ack, oe);
        check("t1_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("t1_addr_oe",  32'(oe),  32'd1);
        write_byte(8'hA5, ack, oe);
        check("t1_data_ack", 32'(ack), 32'(I2C_ACK));
        check("t1_data_oe",  32'(oe),  32'd1);
        bus_stop;
        check("t1_busy_stop",  32'(busy),     32'd0);
        check("t1_rxv_width",  32'(rxv_max),  32'd1);
        check("t1_rx_data",    32'(rx_data),  32'hA5);
        check("t1_sb_empty",   32'(rx_exp_q.size()), 32'd0);

        // Wrong address 0x21
        oe_seen = 1'b0; rxv_seen = 1'b0;
        bus_start;
        write_byte(8'h42, ack, oe);
        check("t2_addr_nack", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h5A, ack, oe);
        check("t2_busy_mid", 32'(busy), 32'd1);
        bus_stop;
        check("t2_oe_never",  32'(oe_seen),  32'd0);
        check("t2_rxv_never", 32'(rxv_seen), 32'd0);
        check("t2_busy_stop", 32'(busy),     32'd0);

        // Overrun: consumer stalled
        rx_ready = 1'b0;
        bus_start;
        write_byte(8'h40, ack, oe);
        check("t3_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h11, ack, oe);
        check("t3_b1_ack",      32'(ack),      32'(I2C_ACK));
        check("t3_b1_valid",    32'(rx_valid), 32'd1);
        check("t3_b1_data",     32'(rx_data),  32'h11);
        check("t3_no_overrun",  32'(overrun),  32'd0);
        write_byte(8'h22, ack, oe);
        check("t3_b2_nack",     32'(ack),      32'(I2C_NACK));
        check("t3_overrun",     32'(overrun),  32'd1);
        check("t3_data_kept",   32'(rx_data),  32'h11);
        bus_stop;
        rx_exp_q.push_back(8'h11);
        rx_ready = 1'b1;
        wclk(3);
        check("t3_drained",     32'(rx_valid), 32'd0);
        check("t3_sb_empty",    32'(rx_exp_q.size()), 32'd0);
        check("t3_overrun_sticky", 32'(overrun), 32'd1);

        // Read two bytes, master ACK then NACK
        txreq_cycles = 0;
        bus_start;
        write_byte(8'h41, ack, oe);
        check("t4_addr_ack", 32'(ack), 32'(I2C_ACK));
        read_byte(rb);
        check("t4_byte0", 32'(rb), 32'h3C);
        send_bit(I2C_ACK);
        read_byte(rb);
        check("t4_byte1", 32'(rb), 32'hC3);
        send_bit(I2C_NACK);
        check("t4_released", 32'(sda_oe), 32'd0);
        check("t4_busy",     32'(busy),   32'd1);
        bus_stop;
        check("t4_txreq_cycles", 32'(txreq_cycles), 32'd2);

        // Repeated START after 4 data bits
        bus_start;
        write_byte(8'h40, ack, oe);
        pat = 8'hA0;
        for (int i = 7; i >= 4; i--) send_bit(pat[i]);
        rx_exp_q.push_back(8'h7E);
        bus_start;
        write_byte(8'h40, ack, oe);
        check("t5_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h7E, ack, oe);
        check("t5_data_ack", 32'(ack), 32'(I2C_ACK));
        bus_stop;
        check("t5_rx_data",  32'(rx_data), 32'h7E);
        check("t5_sb_empty", 32'(rx_exp_q.size()), 32'd0);

        // Reset during the data ACK slot
        bus_start;
        write_byte(8'h40, ack, oe);
        rx_exp_q.push_back(8'h99);
        pat = 8'h99;
        for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        check("t6_ack_driven", 32'(sda_oe), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("t6_async_release", 32'(sda_oe), 32'd0);
        check("t6_busy_reset",    32'(busy),   32'd0);
        wclk(2);
        rst = 1'b0;
        m_scl = 1'b0; wclk(Q);
        bus_stop;
        rx_exp_q.push_back(8'h55);
        bus_start;
        write_byte(8'h40, ack, oe);
        check("t6_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h55, ack, oe);
        check("t6_data_ack", 32'(ack), 32'(I2C_ACK));
        bus_stop;
        check("t6_rx_data",  32'(rx_data), 32'h55);
        check("t6_sb_empty", 32'(rx_exp_q.size()), 32'd0);
        check("t6_overrun_cleared", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
